// File: rtl/cfg_chain_pkg.sv
// Shared types and CRC-8 helper for the configuration chain loader.
package cfg_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_FINISH
    } state_t;

    // Bit-slot phase: A presents a bit (shift_clk low), B raises shift_clk,
    // WAIT is a phase-A stall while the host has no word for us.
    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_WAIT
    } phase_t;

    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam logic [7:0] CRC_INIT = 8'hFF;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        crc8_step = {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8.sv
// Serial MSB-first CRC-8 register; clr reloads the init value, en folds in bit_i.
module cfg_crc8
    import cfg_chain_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    // Next CRC value: clear has priority over a bit update.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC_INIT;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_i);
        end
    end

    // CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads a tile configuration chain from host words, then recirculates it once
// and compares CRCs of sent and returned bits before releasing shift_en.
module cfg_chain_loader
    import cfg_chain_pkg::*;
#(
    parameter int CONF_BITS = 40,
    parameter int NUM_TILES = 4,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_clk,
    output logic              shift_en,
    output logic              cfg_so,
    input  logic              cfg_si,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TOTAL     = CONF_BITS * NUM_TILES;
    localparam int NWORDS    = (TOTAL + WORD_W - 1) / WORD_W;
    localparam int LAST_BITS = TOTAL - (NWORDS - 1) * WORD_W;
    localparam int CNT_W     = $clog2(TOTAL + 1);
    localparam int WCNT_W    = $clog2(NWORDS + 1);
    localparam int BCNT_W    = $clog2(WORD_W + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(TOTAL - 1);
    localparam logic [WCNT_W-1:0] NWORDS_C  = WCNT_W'(NWORDS);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
    localparam logic [BCNT_W-1:0] FULL_C    = BCNT_W'(WORD_W);
    localparam logic [BCNT_W-1:0] LAST_C    = BCNT_W'(LAST_BITS);

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WCNT_W-1:0]   words_q, words_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [BCNT_W-1:0]   buf_cnt_q, buf_cnt_d;
    logic                shift_clk_q, shift_clk_d;
    logic                cfg_so_q, cfg_so_d;
    logic                shift_en_q, shift_en_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                hs;
    logic [WORD_W-1:0]   eff_buf;
    logic [BCNT_W-1:0]   eff_cnt;
    logic                crc_clr, crc_ld_en, crc_rt_en;
    logic [7:0]          crc_ld, crc_rt;

    cfg_crc8 u_crc_load (
        .clk   (clk),
        .rst   (rst),
        .clr   (crc_clr),
        .en    (crc_ld_en),
        .bit_i (cfg_so_q),
        .crc_o (crc_ld)
    );

    cfg_crc8 u_crc_ret (
        .clk   (clk),
        .rst   (rst),
        .clr   (crc_clr),
        .en    (crc_rt_en),
        .bit_i (cfg_si),
        .crc_o (crc_rt)
    );

    // Sequencer: bit-slot phases, word buffering, recirculation and CRC verdict.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        buf_d       = buf_q;
        buf_cnt_d   = buf_cnt_q;
        shift_clk_d = shift_clk_q;
        cfg_so_d    = cfg_so_q;
        shift_en_d  = shift_en_q;
        err_d       = err_q;
        done_d      = 1'b0;
        crc_clr     = 1'b0;
        crc_ld_en   = 1'b0;
        crc_rt_en   = 1'b0;

        // A word arriving this cycle stands in for the (empty) buffer, so the
        // next bit can be taken from it without an extra stall cycle.
        hs      = in_valid && in_ready_q;
        eff_buf = hs ? in_data : buf_q;
        eff_cnt = hs ? ((words_q == LAST_WORD) ? LAST_C : FULL_C) : buf_cnt_q;
        words_d = words_q + WCNT_W'(hs);

        case (state_q)
            ST_IDLE: begin
                shift_clk_d = 1'b0;
                if (start) begin
                    state_d    = ST_LOAD;
                    phase_d    = PH_WAIT;
                    err_d      = 1'b0;
                    crc_clr    = 1'b1;
                    bit_cnt_d  = '0;
                    words_d    = '0;
                    buf_cnt_d  = '0;
                    shift_en_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (phase_q == PH_A) begin
                    shift_clk_d = 1'b1;
                    phase_d     = PH_B;
                    buf_d       = eff_buf;
                    buf_cnt_d   = eff_cnt;
                end else begin
                    shift_clk_d = 1'b0;
                    if (phase_q == PH_B) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        crc_ld_en = 1'b1;
                    end
                    if (phase_q == PH_B && bit_cnt_q == LAST_BIT) begin
                        state_d   = ST_VERIFY;
                        phase_d   = PH_A;
                        bit_cnt_d = '0;
                        cfg_so_d  = cfg_si;
                        crc_rt_en = 1'b1;
                    end else if (eff_cnt != '0) begin
                        cfg_so_d  = eff_buf[WORD_W-1];
                        buf_d     = eff_buf << 1;
                        buf_cnt_d = eff_cnt - BCNT_W'(1);
                        phase_d   = PH_A;
                    end else begin
                        phase_d = PH_WAIT;
                    end
                end
            end
            ST_VERIFY: begin
                if (phase_q == PH_A) begin
                    shift_clk_d = 1'b1;
                    phase_d     = PH_B;
                end else begin
                    shift_clk_d = 1'b0;
                    bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = ST_FINISH;
                        done_d     = 1'b1;
                        shift_en_d = (crc_ld != crc_rt);
                        err_d      = (crc_ld != crc_rt);
                    end else begin
                        cfg_so_d  = cfg_si;
                        crc_rt_en = 1'b1;
                        phase_d   = PH_A;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = (state_d == ST_LOAD) && (buf_cnt_d == '0) && (words_d < NWORDS_C);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_WAIT;
            bit_cnt_q   <= '0;
            words_q     <= '0;
            buf_q       <= '0;
            buf_cnt_q   <= '0;
            shift_clk_q <= 1'b0;
            cfg_so_q    <= 1'b0;
            shift_en_q  <= 1'b1;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            words_q     <= words_d;
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
            shift_clk_q <= shift_clk_d;
            cfg_so_q    <= cfg_so_d;
            shift_en_q  <= shift_en_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign shift_clk = shift_clk_q;
    assign shift_en  = shift_en_q;
    assign cfg_so    = cfg_so_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench: two loaders (8-bit and 16-bit host words) on 40-bit chain models.
module tb_cfg_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic        sen;
        logic [39:0] chain;
        logic        chk_chain;
        int          cyc_lo;
        int          cyc_hi;
    } exp_t;

    // ---------------- 8-bit word instance ----------------
    logic       rst8, start8, in_valid8, in_ready8, shift_clk8, shift_en8;
    logic       cfg_so8, cfg_si8, busy8, done8, err8;
    logic [7:0] in_data8;

    cfg_chain_loader #(.CONF_BITS(40), .NUM_TILES(1), .WORD_W(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .shift_clk(shift_clk8), .shift_en(shift_en8), .cfg_so(cfg_so8),
        .cfg_si(cfg_si8), .busy(busy8), .done(done8), .err(err8)
    );

    logic [39:0] chain8 = '0;
    int          rises8 = 0;
    int          base8  = 0;
    logic        fault8 = 1'b0;
    always @(posedge shift_clk8) begin
        chain8 <= {chain8[38:0], cfg_so8};
        rises8 <= rises8 + 1;
    end
    // Return-path fault corrupts returned bit 17 (sampled after 40+17 rises).
    assign cfg_si8 = chain8[39] ^ (fault8 && ((rises8 - base8) == 57));

    exp_t q8[$];
    int   start_cyc8 = 0;
    int   dones8     = 0;
    int   last_r8    = 0;
    logic prev_sen8  = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (rises8 != last_r8) begin
            last_r8 = rises8;
            if ((rises8 - base8) == 40 && q8.size() > 0 && q8[0].chk_chain)
                check("load8_chain", chain8, q8[0].chain);
        end
        if (done8) begin
            dones8++;
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done8_unexpected: done=1 with no pending load");
            end else begin
                e = q8.pop_front();
                check("done8_err", err8, e.err);
                check("done8_shift_en", shift_en8, e.sen);
                check("done8_sen_before", prev_sen8, 1'b1);
                check("done8_rises", rises8 - base8, 80);
                if (e.chk_chain) check("done8_chain", chain8, e.chain);
                if (e.cyc_lo > 0) begin
                    lat = cyc - start_cyc8;
                    n_checks++;
                    if (lat < e.cyc_lo || lat > e.cyc_hi) begin
                        n_fail++;
                        $display("FAIL done8_latency: got %0d expected %0d..%0d", lat, e.cyc_lo, e.cyc_hi);
                    end
                end
            end
        end
        prev_sen8 = shift_en8;
    end

    task automatic chk_reset8(input string tag);
        check({tag, "_shift_clk"}, shift_clk8, 1'b0);
        check({tag, "_shift_en"},  shift_en8,  1'b1);
        check({tag, "_cfg_so"},    cfg_so8,    1'b0);
        check({tag, "_in_ready"},  in_ready8,  1'b0);
        check({tag, "_busy"},      busy8,      1'b0);
        check({tag, "_done"},      done8,      1'b0);
        check({tag, "_err"},       err8,       1'b0);
    endtask

    task automatic load8(input logic [7:0] w [5], input int gap, input int abort_at);
        int   idx   = 0;
        int   g     = 0;
        int   guard = 0;
        logic hs;
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8     = 1'b0;
        start_cyc8 = cyc;
        base8      = rises8;
        check("start8_err_cleared", err8, 1'b0);
        check("start8_busy", busy8, 1'b1);
        while (idx < 5) begin
            if (abort_at > 0 && (rises8 - base8) >= abort_at) break;
            guard++;
            if (guard > 3000) begin
                n_checks++;
                n_fail++;
                $display("FAIL load8_timeout: sent %0d words expected 5", idx);
                break;
            end
            if (gap == 0) begin
                in_valid8 = 1'b1;
            end else if (g < gap) begin
                in_valid8 = 1'b0;
                if (in_ready8) begin
                    g++;
                    if (g >= 3) check("gap_shift_clk", shift_clk8, 1'b0);
                end
            end else begin
                in_valid8 = 1'b1;
            end
            in_data8 = w[idx];
            hs = in_valid8 && in_ready8;
            @(negedge clk);
            if (hs) begin
                idx++;
                g = 0;
            end
        end
        in_valid8 = 1'b0;
    endtask

    task automatic wait_q8();
        int n = 0;
        while (q8.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done8_timeout: %0d loads pending expected 0", q8.size());
            q8.delete();
        end
    endtask

    // ---------------- 16-bit word instance ----------------
    logic        rst16, start16, in_valid16, in_ready16, shift_clk16, shift_en16;
    logic        cfg_so16, cfg_si16, busy16, done16, err16;
    logic [15:0] in_data16;

    cfg_chain_loader #(.CONF_BITS(40), .NUM_TILES(1), .WORD_W(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .in_data(in_data16), .in_valid(in_valid16),
        .in_ready(in_ready16), .shift_clk(shift_clk16), .shift_en(shift_en16), .cfg_so(cfg_so16),
        .cfg_si(cfg_si16), .busy(busy16), .done(done16), .err(err16)
    );

    logic [39:0] chain16 = '0;
    int          rises16 = 0;
    int          base16  = 0;
    always @(posedge shift_clk16) begin
        chain16 <= {chain16[38:0], cfg_so16};
        rises16 <= rises16 + 1;
    end
    assign cfg_si16 = chain16[39];

    exp_t q16[$];
    int   start_cyc16  = 0;
    int   hs16         = 0;
    logic ready_after3 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (hs16 == 3 && in_ready16) ready_after3 = 1'b1;
        if (in_valid16 && in_ready16) hs16++;
        if (done16) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done16_unexpected: done=1 with no pending load");
            end else begin
                e = q16.pop_front();
                check("done16_err", err16, e.err);
                check("done16_shift_en", shift_en16, e.sen);
                check("done16_chain", chain16, e.chain);
                check("done16_rises", rises16 - base16, 80);
                check("done16_handshakes", hs16, 3);
                check("done16_ready_after3", ready_after3, 1'b0);
                check("done16_in_ready", in_ready16, 1'b0);
                lat = cyc - start_cyc16;
                n_checks++;
                if (lat < e.cyc_lo || lat > e.cyc_hi) begin
                    n_fail++;
                    $display("FAIL done16_latency: got %0d expected %0d..%0d", lat, e.cyc_lo, e.cyc_hi);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [7:0]  nom [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
    logic [15:0] w16 [3] = '{16'hABCD, 16'h1234, 16'h56EF};
    exp_t good, bad;

    initial begin
        int d0;
        int n;
        int idx;
        rst8 = 1'b1; start8 = 1'b0; in_valid8 = 1'b0; in_data8 = '0;
        rst16 = 1'b1; start16 = 1'b0; in_valid16 = 1'b0; in_data16 = '0;
        good = '{err: 1'b0, sen: 1'b0, chain: 40'hA53CFF0081, chk_chain: 1'b1, cyc_lo: 160, cyc_hi: 164};
        bad  = '{err: 1'b1, sen: 1'b1, chain: 40'h0, chk_chain: 1'b0, cyc_lo: 0, cyc_hi: 0};
        repeat (3) @(negedge clk);
        chk_reset8("reset");
        rst8  = 1'b0;
        rst16 = 1'b0;
        @(negedge clk);

        // Nominal load
        q8.push_back(good);
        load8(nom, 0, 0);
        wait_q8();

        // Return-path fault: err set, shift_en held
        fault8 = 1'b1;
        q8.push_back(bad);
        load8(nom, 0, 0);
        wait_q8();
        fault8 = 1'b0;
        repeat (3) @(negedge clk);
        check("fault_err_sticky", err8, 1'b1);
        check("fault_shift_en_held", shift_en8, 1'b1);

        // Host stalls between words (next start also clears err)
        good.cyc_lo = 0;
        q8.push_back(good);
        load8(nom, 5, 0);
        wait_q8();

        // Asynchronous reset in the middle of a load
        load8(nom, 0, 20);
        #2 rst8 = 1'b1;
        #1 chk_reset8("midrst");
        @(negedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        good.cyc_lo = 160;
        q8.push_back(good);
        load8(nom, 0, 0);
        wait_q8();

        // start pulsed during VERIFY is ignored
        d0 = dones8;
        q8.push_back(good);
        load8(nom, 0, 0);
        n = 0;
        while ((rises8 - base8) < 50 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("verify_reached", ((rises8 - base8) >= 50), 1'b1);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("busy_during_verify", busy8, 1'b1);
        wait_q8();
        repeat (200) @(negedge clk);
        check("single_done", dones8 - d0, 1);
        check("busy_start_err", err8, 1'b0);
        check("idle_after_ignored_start", busy8, 1'b0);

        // 16-bit words with a partial final word
        q16.push_back('{err: 1'b0, sen: 1'b0, chain: 40'hABCD123456, chk_chain: 1'b1, cyc_lo: 160, cyc_hi: 164});
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16     = 1'b0;
        start_cyc16 = cyc;
        base16      = rises16;
        idx = 0;
        n   = 0;
        while (idx < 3 && n < 1000) begin
            in_valid16 = 1'b1;
            in_data16  = w16[idx];
            if (in_ready16) idx++;
            @(negedge clk);
            n++;
        end
        in_valid16 = 1'b0;
        check("load16_words_sent", idx, 3);
        n = 0;
        while (q16.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done16_timeout: %0d loads pending expected 0", q16.size());
        end
        repeat (5) @(negedge clk);
        check("load16_handshakes_final", hs16, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
